// File: rtl/spi_uc_pkg.sv
// ---------------------------------------------------------------------------
// spi_uc_pkg : shared types and constants for the microcontroller SPI slave
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spi_uc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_BITS  = 16;
  // SYS_CLK must run at least this many times faster than SCK
  localparam int MIN_CLK_RATIO = 6;

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge : multi-flop synchroniser with single-cycle rise/fall strobes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_q    = r_sync[SYNC_STAGES-1];
  assign o_rise = ~r_prev &  o_q;
  assign o_fall =  r_prev & ~o_q;

endmodule

`default_nettype wire

// File: rtl/spi_slave_uc.sv
// ---------------------------------------------------------------------------
// spi_slave_uc : oversampling SPI slave, one BITS-wide word each way per frame
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_slave_uc
  import spi_uc_pkg::*;
#(
  parameter int BITS        = DEFAULT_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic            SYS_CLK,
  input  logic            RST,
  input  logic            SCK,
  input  logic            CSbar,
  input  logic            MOSI,
  output logic            MISO,
  output logic            MISO_OE,
  input  logic [BITS-1:0] TX_DATA,
  output logic [BITS-1:0] RX_DATA,
  output logic            RX_VALID,
  input  logic            RX_ACK,
  output logic            OVERRUN,
  output logic            FRAME_ERR,
  output logic            BUSY
);

  localparam int            CW     = $clog2(BITS + 1);
  localparam logic [CW-1:0] c_LAST = CW'(BITS - 1);

  logic w_sck_q, w_sck_rise, w_sck_fall;
  logic w_cs_q, w_cs_rise, w_cs_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(SYS_CLK), .rst_n(RST), .i_d(SCK),
    .o_q(w_sck_q), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(SYS_CLK), .rst_n(RST), .i_d(CSbar),
    .o_q(w_cs_q), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(SYS_CLK), .rst_n(RST), .i_d(MOSI),
    .o_q(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  assign w_unused = &{w_sck_q, w_sck_rise, w_cs_q, w_mosi_rise, w_mosi_fall};

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [BITS-1:0] r_tx_shift;
  logic [BITS-1:0] r_rx_shift;
  logic            r_miso;
  logic            r_oe;
  logic            r_commit;
  logic            r_frame_err;
  logic [BITS-1:0] r_rx_data;
  logic            r_rx_valid;
  logic            r_overrun;

  // cs_rise is tested before sck_fall so a coincident bit is dropped
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_miso      <= 1'b0;
      r_oe        <= 1'b0;
      r_commit    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_commit    <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cs_fall) begin
            r_tx_shift <= TX_DATA;
            r_miso     <= TX_DATA[BITS-1];
            r_cnt      <= '0;
            r_oe       <= 1'b1;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_cs_rise) begin
            r_state     <= IDLE;
            r_oe        <= 1'b0;
            r_miso      <= 1'b0;
            r_frame_err <= 1'b1;
          end else if (w_sck_fall) begin
            r_rx_shift <= {r_rx_shift[BITS-2:0], w_mosi};
            r_tx_shift <= {r_tx_shift[BITS-2:0], 1'b0};
            r_miso     <= r_tx_shift[BITS-2];
            r_cnt      <= r_cnt + 1'b1;
            if (r_cnt == c_LAST) begin
              r_state  <= DONE;
              r_commit <= 1'b1;
            end
          end
        end
        DONE: begin
          r_miso <= 1'b0;
          if (w_cs_rise) begin
            r_state <= IDLE;
            r_oe    <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_oe    <= 1'b0;
          r_miso  <= 1'b0;
        end
      endcase
    end
  end

  // A commit outranks a coincident acknowledge
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else if (r_commit) begin
      r_rx_data  <= r_rx_shift;
      r_rx_valid <= 1'b1;
      r_overrun  <= r_rx_valid & ~RX_ACK;
    end else begin
      r_overrun <= 1'b0;
      if (RX_ACK) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign MISO      = r_miso;
  assign MISO_OE   = r_oe;
  assign RX_DATA   = r_rx_data;
  assign RX_VALID  = r_rx_valid;
  assign OVERRUN   = r_overrun;
  assign FRAME_ERR = r_frame_err;
  assign BUSY      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_uc.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_uc : directed + randomised frames against a word-level model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spi_slave_uc;
  import spi_uc_pkg::*;

  localparam int BITS     = 16;
  localparam int SYNC     = 2;
  localparam int SCK_HALF = (MIN_CLK_RATIO + 2) / 2;

  logic            SYS_CLK = 1'b0;
  logic            RST = 1'b0;
  logic            SCK = 1'b0;
  logic            CSbar = 1'b1;
  logic            MOSI = 1'b0;
  logic            MISO, MISO_OE;
  logic [BITS-1:0] TX_DATA = '0;
  logic [BITS-1:0] RX_DATA;
  logic            RX_VALID;
  logic            RX_ACK = 1'b0;
  logic            OVERRUN, FRAME_ERR, BUSY;

  spi_slave_uc #(.BITS(BITS), .SYNC_STAGES(SYNC)) dut (
    .SYS_CLK(SYS_CLK), .RST(RST), .SCK(SCK), .CSbar(CSbar), .MOSI(MOSI),
    .MISO(MISO), .MISO_OE(MISO_OE), .TX_DATA(TX_DATA), .RX_DATA(RX_DATA),
    .RX_VALID(RX_VALID), .RX_ACK(RX_ACK), .OVERRUN(OVERRUN),
    .FRAME_ERR(FRAME_ERR), .BUSY(BUSY)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge SYS_CLK);
    #1;
  endtask

  // Event monitor on the falling edge, clear of the active edge
  int n_rise = 0, n_ovr = 0, n_ferr = 0, oe_bad = 0, since_low = 0;
  logic prev_valid = 1'b0;
  always @(negedge SYS_CLK) begin
    if (RX_VALID && !prev_valid) n_rise++;
    prev_valid = RX_VALID;
    if (OVERRUN)   n_ovr++;
    if (FRAME_ERR) n_ferr++;
    if (!CSbar) since_low = 0; else since_low++;
    if (MISO_OE && since_low > SYNC + 2) oe_bad++;
  end

  // Word-level reference model of the receive side
  logic            m_valid = 1'b0;
  logic [BITS-1:0] m_data  = '0;

  task automatic sck_cycle(input logic mosi_bit, output logic miso_s);
    SCK    = 1'b1;
    miso_s = MISO;
    MOSI   = mosi_bit;
    tick(SCK_HALF);
    SCK    = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [BITS-1:0] w,
                           input logic [BITS-1:0] tx, input int nsck,
                           input bit ack_at_commit);
    logic [BITS-1:0] cap, mask;
    logic extra, s, vb, exp_commit;
    int r0, o0, f0, b0;
    cap = '0; extra = 1'b0;
    vb = m_valid;
    exp_commit = (nsck >= BITS);
    r0 = n_rise; o0 = n_ovr; f0 = n_ferr; b0 = oe_bad;
    TX_DATA = tx;
    CSbar = 1'b0;
    tick(SCK_HALF);
    TX_DATA = BITS'($urandom);
    check({tag, "_oe_on"}, {31'd0, MISO_OE}, 32'd1);
    for (int i = 0; i < nsck; i++) begin
      sck_cycle(i < BITS ? w[BITS-1-i] : 1'($urandom), s);
      if (i < BITS) cap[BITS-1-i] = s; else extra |= s;
      if (i == BITS - 1) begin
        tick(SYNC + 1);
        check({tag, "_lat_pre"}, {31'd0, RX_VALID}, {31'd0, vb});
        if (ack_at_commit) RX_ACK = 1'b1;
        tick(1);
        RX_ACK = 1'b0;
        check({tag, "_lat"}, {31'd0, RX_VALID}, 32'd1);
        tick(SCK_HALF - SYNC - 2);
      end else begin
        tick(SCK_HALF);
      end
    end
    tick(SCK_HALF);
    if (exp_commit) check({tag, "_miso_done"}, {31'd0, MISO}, 32'd0);
    CSbar = 1'b1;
    tick(3 * SCK_HALF);

    if (exp_commit) begin
      m_valid = 1'b1;
      m_data  = w;
    end
    mask = (nsck >= BITS) ? '1 : ~({BITS{1'b1}} >> nsck);
    check({tag, "_miso"}, 32'(cap & mask), 32'(tx & mask));
    check({tag, "_miso_x"}, {31'd0, extra}, 32'd0);
    check({tag, "_rxd"}, 32'(RX_DATA), 32'(m_data));
    check({tag, "_vld"}, {31'd0, RX_VALID}, {31'd0, m_valid});
    check({tag, "_rise"}, n_rise - r0, (exp_commit && !vb) ? 1 : 0);
    check({tag, "_ovr"}, n_ovr - o0, (exp_commit && vb && !ack_at_commit) ? 1 : 0);
    check({tag, "_ferr"}, n_ferr - f0, exp_commit ? 0 : 1);
    check({tag, "_oe_off"}, oe_bad - b0, 0);
    check({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
  endtask

  task automatic do_ack(input string tag);
    RX_ACK = 1'b1;
    tick(1);
    RX_ACK = 1'b0;
    m_valid = 1'b0;
    check(tag, {31'd0, RX_VALID}, 32'd0);
  endtask

  function automatic logic [31:0] out_vec();
    return {10'd0, MISO, MISO_OE, RX_VALID, OVERRUN, FRAME_ERR, BUSY, RX_DATA};
  endfunction

  initial begin
    #200000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic s;
    #2;
    check("reset_outs", out_vec(), 32'd0);
    tick(3);
    RST = 1'b1;
    tick(3);
    check("idle_outs", out_vec(), 32'd0);

    run_frame("basic", 16'h1234, 16'hA55A, 16, 1'b0);
    do_ack("basic_ack");

    run_frame("b2b1", 16'h00FF, 16'h5AA5, 16, 1'b0);
    run_frame("b2b2", 16'hFF00, 16'h0F0F, 16, 1'b0);
    do_ack("b2b_ack");

    run_frame("abort", 16'h6789, 16'hCAFE, 9, 1'b0);

    run_frame("extra", 16'hBEEF, 16'h8001, 20, 1'b0);

    // Reset in the middle of a frame
    CSbar = 1'b0;
    tick(SCK_HALF);
    for (int i = 0; i < 5; i++) begin
      sck_cycle(1'($urandom), s);
      tick(SCK_HALF);
    end
    RST = 1'b0;
    #2;
    check("midrst_outs", out_vec(), 32'd0);
    CSbar = 1'b1;
    SCK = 1'b0;
    tick(3);
    RST = 1'b1;
    m_valid = 1'b0;
    m_data  = '0;
    tick(4);
    run_frame("post_rst", 16'hC3C3, 16'h3C3C, 16, 1'b0);

    // Commit and acknowledge land on the same edge
    run_frame("coll", 16'h7E81, 16'h1111, 16, 1'b1);
    check("coll_word", 32'(RX_DATA), 32'h7E81);
    do_ack("coll_ack");
    do_ack("idle_ack");

    for (int k = 0; k < 12; k++) begin
      int nsck;
      nsck = ($urandom_range(0, 3) == 0) ? $urandom_range(0, BITS - 1)
                                         : $urandom_range(BITS, BITS + 4);
      run_frame($sformatf("rnd%0d", k), BITS'($urandom), BITS'($urandom),
                nsck, 1'($urandom));
      if ($urandom_range(0, 1) == 1) do_ack($sformatf("rnd%0d_ack", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
